data_mem_responder: RTL
=======================

# data_mem_responder

Multi-cycle data-memory responder that answers the CPU's MEM-stage load/store requests (EX/MEM `MemRead`/`MemWrite`, ALU address, store data) with a fixed, parameterised latency. It sits between the EX/MEM pipeline register and the MEM/WB register, replacing a single-cycle data memory. It asserts a stall to freeze the pipeline while an access is in flight, then presents read data and a one-cycle acknowledge.

## Interface
- `DEPTH_WORDS`, 256 — number of 32-bit words; power of two, ≥ 2.
- `LATENCY`, 4 — BUSY cycles per access; ≥ 1.

- `clk_i` in 1 — single clock; all state updates on the rising edge.
- `rst_i` in 1 — synchronous, active-high reset.
- `addr_i` in 32 — byte address from EX/MEM ALU result.
- `data_i` in 32 — store data from EX/MEM.
- `MemRead_i` in 1 — load request; held stable by the CPU while `stall_o` = 1.
- `MemWrite_i` in 1 — store request; held stable by the CPU while `stall_o` = 1.
- `data_o` out 32 — last read data; captured by MEM/WB.
- `stall_o` out 1 — freeze PC, IF/ID, ID/EX and EX/MEM.
- `ack_o` out 1 — one-cycle pulse when the access completes.

## Operation
- Word index = `addr_i[log2(DEPTH_WORDS)+1:2]`.
  - `addr_i[1:0]` is ignored, so there is no misalignment fault.
  - Upper bits are ignored, so addresses alias modulo `DEPTH_WORDS*4`.
- Request = `MemRead_i | MemWrite_i`. If both are high, the access is a write; no read occurs and `data_o` is unchanged.
- FSM states are IDLE, BUSY and DONE.
  - IDLE with request:
    - `stall_o` = 1 combinationally in the same cycle.
    - Latch the word index, `data_i` and the op.
    - Load counter with `LATENCY-1` and go to BUSY.
  - IDLE without request: stay in IDLE; `stall_o` = 0.
  - BUSY: `stall_o` = 1.
    - If counter ≠ 0: decrement.
    - If counter = 0: perform the access using the latched values (write: `mem[idx] <= data`; read: `data_o <= mem[idx]`), then go to DONE.
  - DONE: `stall_o` = 0 and `ack_o` = 1.
    - Inputs are ignored this cycle; the same instruction is still in EX/MEM and must not restart.
    - Always go to IDLE next cycle.
- Inputs are sampled only in IDLE. Changes to `addr_i`/`data_i` during BUSY/DONE have no effect.
- `data_o` holds its value across writes and idle cycles. It changes only on read completion or reset.
- The storage array is not cleared by reset; contents after power-up are undefined.

## Timing
- Reset values: state IDLE, counter 0, `stall_o` 0, `ack_o` 0, `data_o` 0.
- Cycle t0 = the IDLE cycle in which the request is seen.
  - `stall_o` is high from t0 through t0+LATENCY, i.e. `LATENCY+1` cycles.
  - `ack_o` is high and `data_o` is valid in t0+LATENCY+1.
  - The next request can be accepted at t0+LATENCY+2.
- A request held continuously across two instructions gives one access every `LATENCY+2` cycles.
- Reset mid-operation (BUSY or DONE):
  - Return to IDLE next edge with all outputs at reset values.
  - A pending write that has not reached its counter-0 cycle is discarded; the array is unmodified.
  - Reset dominates any same-cycle access.
- `ack_o` is never high while `stall_o` is high.

## Test plan
- LATENCY=4: store 0xDEADBEEF at 0x10, then load 0x10.
  - Store: `stall_o` high for 5 cycles, `ack_o` in cycle 5.
  - Load: `data_o` = 0xDEADBEEF in its ack cycle.
- Aliasing (DEPTH=256): store 0x11111111 at 0x404, then load 0x007 → `data_o` = 0x11111111.
- Store 0x0 to 0x20, then store 0xA5A5A5A5 to 0x20 and assert `rst_i` at t0+2.
  - Cycle after reset: `stall_o` = 0.
  - Subsequent load of 0x20 returns 0x00000000.
- `MemRead_i` and `MemWrite_i` both high with `data_i` = 0x12345678 at 0x30, after a prior load gave `data_o` = 0xCAFEF00D.
  - `data_o` stays 0xCAFEF00D.
  - A later load of 0x30 returns 0x12345678.
- `MemRead_i` held high for 12 cycles; `addr_i` = 0x40, then switched to 0x44 during the first DONE cycle.
  - Acks at cycles 5 and 11.
  - Second read returns `mem[0x44]`.
  - The DONE-cycle change does not disturb the first result.

Source files
------------

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency data-memory responder for the MEM stage
// Stalls the pipeline while an access is in flight, then pulses ack with read data.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        ack_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state;
    logic [CW-1:0]  count;
    logic [AW-1:0]  idx;
    logic [31:0]    wdata;
    logic           is_write;
    logic           req;
    logic           do_access;
    logic           unused_addr_bits;
    logic [31:0]    mem [DEPTH_WORDS];

    assign req       = MemRead_i | MemWrite_i;
    assign do_access = (state == BUSY) && (count == '0) && !rst_i;
    // Stall must rise in the request cycle itself so EX/MEM holds the instruction.
    assign stall_o   = (state == BUSY) || ((state == IDLE) && req);
    assign unused_addr_bits = ^{addr_i[31:AW+2], addr_i[1:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            count    <= '0;
            idx      <= '0;
            wdata    <= '0;
            is_write <= 1'b0;
            data_o   <= '0;
            ack_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack_o <= 1'b0;
                    if (req) begin
                        idx      <= addr_i[AW+1:2];
                        wdata    <= data_i;
                        is_write <= MemWrite_i;
                        count    <= CW'(LATENCY - 1);
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end else begin
                        if (!is_write) begin
                            data_o <= mem[idx];
                        end
                        ack_o <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // The same instruction is still in EX/MEM; never restart from here.
                    ack_o <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ack_o <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_access && is_write) begin
            mem[idx] <= wdata;
        end
    end
endmodule
